data_mem_1k: RTL and testbench

1 KiB word-organised data memory for the single-cycle MIPS datapath, sitting behind the ALU address path in the MEM stage.
- 256 x 32-bit words, addressed by a 10-bit byte address.
- Synchronous write on the rising clock edge.
- Combinational (asynchronous) read.
- Asynchronous active-high reset clears the whole array.

---
 rtl/mips_pkg.sv | 12 +
 rtl/data_mem_1k.sv | 41 ++++
 tb/tb_data_mem_1k.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the data-memory word-index helper.
package mips_pkg;

    localparam int DATA_W    = 32;
    localparam int DM_ADDR_W = 10;

    // A byte address selects the word that contains it; the low two bits are dropped.
    function automatic logic [DM_ADDR_W-3:0] word_idx(input logic [DM_ADDR_W-1:0] a);
        return a[DM_ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/data_mem_1k.sv
// 1 KiB word-organised data memory for the MEM stage: synchronous write,
// combinational read, asynchronous reset that clears every word.
module data_mem_1k
    import mips_pkg::*;
#(
    parameter int ADDR_W = DM_ADDR_W,
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int DEPTH  = 2 ** (ADDR_W - 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-3:0] widx;

    assign widx = word_idx(addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[widx] <= din;
        end
    end

    // Gating on rst keeps dout at zero for the whole reset window, including
    // the instant reset rises.
    assign dout = rst ? '0 : mem[widx];

    // Byte-offset bits intentionally select nothing.
    logic unused_ok;
    assign unused_ok = ^addr[1:0];

endmodule

// File: tb/tb_data_mem_1k.sv
// Directed bench for data_mem_1k: reset, write/readback, alignment, boundary, reset-after-data.
`timescale 1ns/1ps
module tb_data_mem_1k;

    logic        clk;
    logic        rst;
    logic        we;
    logic [31:0] din;
    logic [9:0]  addr;
    logic [31:0] dout;

    int compared;
    int mismatched;

    logic [31:0] pow9 [10];

    data_mem_1k dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .din  (din),
        .addr (addr),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write one word: drive on the falling edge, commit on the rising edge, sample 1 ns later.
    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        we   = 1'b1;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, dout, exp);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        pow9[0] = 32'd1;        pow9[1] = 32'd9;        pow9[2] = 32'd81;
        pow9[3] = 32'd729;      pow9[4] = 32'd6561;     pow9[5] = 32'd59049;
        pow9[6] = 32'd531441;   pow9[7] = 32'd4782969;  pow9[8] = 32'd43046721;
        pow9[9] = 32'h17179149;

        rst  = 1'b0;
        we   = 1'b0;
        din  = 32'h0;
        addr = 10'd0;

        // 1. Reset pulse between clock edges (first posedge is at t=10)
        #1 rst = 1'b1;
        rd("rst_a0", 10'd0, 32'h0);
        rd("rst_a4", 10'd4, 32'h0);
        rd("rst_a1020", 10'd1020, 32'h0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        rd("post_rst_a0", 10'd0, 32'h0);
        rd("post_rst_a512", 10'd512, 32'h0);
        rd("post_rst_a1020", 10'd1020, 32'h0);

        // 2. Write/readback of powers of nine
        for (int i = 0; i < 10; i++) begin
            wr(10'(4 * i), pow9[i]);
            addr = 10'(4 * i);
            #1;
            check($sformatf("wr_pow9_%0d", i), dout, pow9[i]);
        end

        // 3. Read-only reverse order, clocking each step with din=0
        we  = 1'b0;
        din = 32'h0;
        for (int i = 9; i >= 0; i--) begin
            @(negedge clk);
            addr = 10'(4 * i);
            @(posedge clk);
            #1;
            check($sformatf("rd_pow9_%0d", i), dout, pow9[i]);
        end

        // 4. Unaligned access
        wr(10'd8, 32'hDEADBEEF);
        rd("unal_a9", 10'd9, 32'hDEADBEEF);
        rd("unal_a10", 10'd10, 32'hDEADBEEF);
        rd("unal_a11", 10'd11, 32'hDEADBEEF);
        wr(10'd11, 32'h12345678);
        rd("unal_a8", 10'd8, 32'h12345678);
        rd("unal_a4_kept", 10'd4, 32'd9);

        // 5. Top boundary
        wr(10'd1020, 32'hA5A5A5A5);
        for (int a = 1020; a < 1024; a++) begin
            rd($sformatf("top_a%0d", a), 10'(a), 32'hA5A5A5A5);
        end
        rd("top_a0_kept", 10'd0, 32'd1);

        // 6. Reset after data, with a write pending while rst is high
        for (int i = 0; i < 10; i++) begin
            wr(10'(4 * i), 32'hC0DE0000 + 32'(i));
        end
        rd("refill_a36", 10'd36, 32'hC0DE0009);
        @(negedge clk);
        we   = 1'b1;
        din  = 32'hFFFFFFFF;
        addr = 10'd16;
        #2 rst = 1'b1;
        #1;
        check("rst_now_a16", dout, 32'h0);
        rd("rst_now_a0", 10'd0, 32'h0);
        rd("rst_now_a36", 10'd36, 32'h0);
        addr = 10'd16;
        @(posedge clk);
        #1;
        check("rst_blocks_wr", dout, 32'h0);
        @(negedge clk);
        we  = 1'b0;
        rst = 1'b0;
        #1;
        check("after_rst_a16", dout, 32'h0);
        rd("after_rst_a20", 10'd20, 32'h0);
        rd("after_rst_a1020", 10'd1020, 32'h0);
        wr(10'd16, 32'h00000077);
        rd("first_wr_after_rst", 10'd16, 32'h00000077);
        rd("neighbour_a12", 10'd12, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
